// File: rtl/exp_stream_ctrl.sv
// Streams a vector of fp16 elements through a single-register expunit stage,
// handling valid/ready on both sides, per-vector counting and status capture.
module exp_stream_ctrl #(
  parameter int LEN_W    = 10,
  parameter int STATUS_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [LEN_W-1:0]    vec_len,
  output logic                busy,
  output logic                done,
  input  logic                in_valid,
  input  logic [15:0]         in_data,
  output logic                in_ready,
  output logic [15:0]         exp_a,
  output logic                exp_stage_run,
  input  logic [15:0]         exp_z,
  input  logic [STATUS_W-1:0] exp_status,
  output logic                out_valid,
  output logic [15:0]         out_data,
  output logic                out_last,
  input  logic                out_ready,
  output logic [STATUS_W-1:0] sticky_status,
  output logic                pos_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q, issued, retired;
  logic [LEN_W-1:0] issued_nxt, retired_nxt;
  logic             s1_valid;
  logic             advance, accept, retire, start_ok, in_pos;

  // The expunit register may only load when its current content is free to go.
  assign advance       = !s1_valid || out_ready;
  assign in_ready      = (state == RUN) && (issued < len_q) && advance;
  assign accept        = in_ready && in_valid;
  assign retire        = s1_valid && out_ready;
  assign start_ok      = (state == IDLE) && start;
  assign in_pos        = !in_data[15] && (|in_data[14:0]);

  assign exp_a         = in_data;
  assign exp_stage_run = advance && (state != IDLE);

  assign out_valid     = s1_valid;
  assign out_data      = exp_z;
  assign out_last      = s1_valid && (retired == len_q - LEN_W'(1));

  assign busy          = (state == RUN) || (state == DRAIN);
  assign done          = (state == DONE);

  assign issued_nxt    = issued  + LEN_W'(accept);
  assign retired_nxt   = retired + LEN_W'(retire);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (vec_len == '0) ? DONE : RUN;
      end
      RUN: begin
        // Last retire landing while still in RUN skips DRAIN entirely.
        if (retired_nxt == len_q)     state_nxt = DONE;
        else if (issued_nxt == len_q) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (retired_nxt == len_q) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      s1_valid      <= 1'b0;
      len_q         <= '0;
      issued        <= '0;
      retired       <= '0;
      sticky_status <= '0;
      pos_err       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (advance) s1_valid <= accept;
      if (start_ok) begin
        len_q         <= vec_len;
        issued        <= '0;
        retired       <= '0;
        sticky_status <= '0;
        pos_err       <= 1'b0;
      end else begin
        issued  <= issued_nxt;
        retired <= retired_nxt;
        if (retire)           sticky_status <= sticky_status | exp_status;
        if (accept && in_pos) pos_err       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_exp_stream_ctrl.sv
// Bench for exp_stream_ctrl: stand-in expunit, directed vector table, hand
// sequences for start/reset corners, and randomized vectors vs a queue model.
module tb_exp_stream_ctrl;
  localparam int LEN_W    = 10;
  localparam int STATUS_W = 8;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic [LEN_W-1:0]    vec_len = '0;
  logic                busy, done;
  logic                in_valid = 1'b0;
  logic [15:0]         in_data = '0;
  logic                in_ready;
  logic [15:0]         exp_a;
  logic                exp_stage_run;
  logic [15:0]         exp_z;
  logic [STATUS_W-1:0] exp_status;
  logic                out_valid;
  logic [15:0]         out_data;
  logic                out_last;
  logic                out_ready = 1'b0;
  logic [STATUS_W-1:0] sticky_status;
  logic                pos_err;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] vin[$];
  logic [15:0] vz[$];

  exp_stream_ctrl #(.LEN_W(LEN_W), .STATUS_W(STATUS_W)) dut (
    .clk(clk), .reset(reset), .start(start), .vec_len(vec_len),
    .busy(busy), .done(done), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .exp_a(exp_a), .exp_stage_run(exp_stage_run),
    .exp_z(exp_z), .exp_status(exp_status), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .sticky_status(sticky_status), .pos_err(pos_err)
  );

  always #5 clk = ~clk;

  // Stand-in expunit: exact table for the known points, a bijective scramble elsewhere.
  function automatic logic [15:0] unit_z(input logic [15:0] a);
    case (a)
      16'h0000, 16'h8000: return 16'h3C00;
      16'hBC00:           return 16'h35E3;
      16'hC000:           return 16'h3055;
      16'hC200:           return 16'h2A5F;
      16'h3C00:           return 16'h4170;
      default:            return {a[7:0], a[15:8]} ^ 16'h1357;
    endcase
  endfunction

  function automatic logic [STATUS_W-1:0] unit_st(input logic [15:0] a);
    return a[15:8] ^ a[7:0];
  endfunction

  function automatic bit is_pos(input logic [15:0] a);
    return !a[15] && (a[14:0] != 15'd0);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_z      <= '0;
      exp_status <= '0;
    end else if (exp_stage_run) begin
      exp_z      <= unit_z(exp_a);
      exp_status <= unit_st(exp_a);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Runs one vector from vin/vz; the model is "k-th accepted input -> k-th result".
  task automatic run_vec(input int len, input int gap_pct, input int stall_pct,
                         input bit stall3, input bit pos_exp, input string tag);
    int ip, op, cyc, last_ret, stall_left;
    bit seen_done, in_bad, busy_bad, run_bad, out_bad;
    logic [STATUS_W-1:0] st_exp;
    st_exp = '0;
    for (int i = 0; i < len; i++) st_exp |= unit_st(vin[i]);
    @(negedge clk);
    start = 1'b1; vec_len = LEN_W'(len); in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    ip = 0; op = 0; cyc = 0; last_ret = -1; stall_left = stall3 ? 3 : 0;
    seen_done = 0; in_bad = 0; busy_bad = 0; run_bad = 0; out_bad = 0;
    while (!seen_done && cyc < 4000) begin
      start    = ($urandom_range(4) == 0);
      vec_len  = LEN_W'($urandom_range(7));
      in_valid = (ip < len) ? ($urandom_range(99) >= gap_pct) : 1'($urandom_range(1));
      in_data  = (ip < len) ? vin[ip] : 16'($urandom);
      if (stall3 && op >= 1 && stall_left > 0) begin
        out_ready = 1'b0; stall_left--;
      end else out_ready = ($urandom_range(99) >= stall_pct);
      #1;
      if (cyc == 0) check({tag, " cleared"}, {sticky_status, pos_err}, 0);
      if (done) begin
        seen_done = 1;
        check({tag, " done timing"}, cyc, last_ret + 1);
        check({tag, " busy at done"}, busy, 0);
      end else begin
        if (busy !== (len != 0)) busy_bad = 1;
        if (exp_a !== in_data) run_bad = 1;
        if (in_ready !== ((ip < len) && (!out_valid || out_ready))) in_bad = 1;
        if (exp_stage_run !== (!out_valid || out_ready)) run_bad = 1;
        if (out_valid) begin
          if (stall3 && !out_ready)
            check({tag, " stall hold"}, {in_ready, exp_stage_run}, 2'b00);
          if (op < len) check($sformatf("%s out%0d", tag, op), {out_data, out_last},
                              {vz[op], 1'(op == len - 1)});
          else out_bad = 1;
          if (out_ready) begin op++; last_ret = cyc; end
        end
        if (in_valid && in_ready) ip++;
      end
      @(negedge clk);
      cyc++;
    end
    if (!seen_done) check({tag, " done timeout"}, 0, 1);
    check({tag, " count in/out"}, {16'(ip), 16'(op)}, {16'(len), 16'(len)});
    check({tag, " sticky_status"}, sticky_status, st_exp);
    check({tag, " pos_err"}, pos_err, pos_exp);
    check({tag, " handshake rules"}, {in_bad, busy_bad, run_bad, out_bad}, 0);
    if (gap_pct == 0 && stall_pct == 0 && !stall3 && len > 0)
      check({tag, " throughput"}, last_ret, len);
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check({tag, " done one cycle"}, {done, busy}, 2'b00);
  endtask

  typedef struct {
    int               len;
    logic [3:0][15:0] d;
    logic [3:0][15:0] z;
    bit               stall3;
    bit               pos;
  } vec_t;

  function automatic vec_t mk(input int len, input logic [15:0] d0, d1, d2, d3,
                              input logic [15:0] z0, z1, z2, z3, input bit s, input bit p);
    vec_t v;
    v.len = len; v.d = {d3, d2, d1, d0}; v.z = {z3, z2, z1, z0}; v.stall3 = s; v.pos = p;
    return v;
  endfunction

  initial begin
    vec_t tbl[6];
    int   len;
    logic [15:0] d;
    bit   p;

    tbl[0] = mk(1, 16'h0000, 0, 0, 0, 16'h3C00, 0, 0, 0, 0, 0);
    tbl[1] = mk(4, 16'hBC00, 16'hC000, 16'hC200, 16'h0000,
                16'h35E3, 16'h3055, 16'h2A5F, 16'h3C00, 0, 0);
    tbl[2] = mk(4, 16'hBC00, 16'hC000, 16'hC200, 16'h0000,
                16'h35E3, 16'h3055, 16'h2A5F, 16'h3C00, 1, 0);
    tbl[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4] = mk(2, 16'h3C00, 16'hBC00, 0, 0, 16'h4170, 16'h35E3, 0, 0, 0, 1);
    tbl[5] = mk(2, 16'h8000, 16'hC000, 0, 0, 16'h3C00, 16'h3055, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    check("reset outputs", {busy, done, in_ready, out_valid, out_last, exp_stage_run,
                            sticky_status, pos_err}, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int t = 0; t < 6; t++) begin
      vin.delete(); vz.delete();
      for (int i = 0; i < tbl[t].len; i++) begin
        vin.push_back(tbl[t].d[i]);
        vz.push_back(tbl[t].z[i]);
      end
      run_vec(tbl[t].len, 0, 0, tbl[t].stall3, tbl[t].pos, $sformatf("tbl%0d", t));
    end

    // start in DONE is ignored; start in the following IDLE cycle is honoured
    @(negedge clk);
    start = 1'b1; vec_len = '0;
    @(negedge clk); #1;
    check("zero-len done", done, 1);
    @(negedge clk); #1;
    check("start in DONE ignored", {done, busy}, 2'b00);
    @(negedge clk); #1;
    check("start in IDLE honoured", done, 1);
    start = 1'b0;
    @(negedge clk); #1;
    check("back to idle", {done, busy}, 2'b00);

    // reset with an element sitting in the unit register
    @(negedge clk);
    start = 1'b1; vec_len = LEN_W'(3); out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 16'hBC00;
    @(negedge clk);
    in_valid = 1'b0; #1;
    check("pre-reset out_valid", {out_valid, busy}, 2'b11);
    reset = 1'b0; #1;
    check("async reset drop", {out_valid, busy, in_ready, done}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    vin.delete(); vz.delete();
    vin.push_back(16'hC000); vz.push_back(16'h3055);
    vin.push_back(16'hBC00); vz.push_back(16'h35E3);
    run_vec(2, 0, 0, 0, 0, "post-reset");

    for (int r = 0; r < 24; r++) begin
      vin.delete(); vz.delete();
      len = (r == 0) ? 40 : int'($urandom_range(12));
      p = 0;
      for (int i = 0; i < len; i++) begin
        d = 16'($urandom);
        if ($urandom_range(9) != 0) d[15] = 1'b1;
        if (is_pos(d)) p = 1;
        vin.push_back(d);
        vz.push_back(unit_z(d));
      end
      if (r == 0) run_vec(len, 0, 0, 0, p, "rnd-full");
      else run_vec(len, 30, 35, 0, p, $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
